// File: rtl/histogram_frame_sequencer_pkg.sv
// Shared types and constants for the histogram frame sequencer and its readout streamer.
package histogram_frame_sequencer_pkg;

    localparam int DEF_BIN_W   = 10;
    localparam int DEF_COUNT_W = 24;

    // Histogram port direction encoding
    localparam logic HIST_READ  = 1'b0;
    localparam logic HIST_WRITE = 1'b1;

    typedef enum logic [3:0] {
        IDLE,
        CLEAR,
        ARMED,
        ACCUM,
        DRAIN,
        RD_ADDR,
        RD_WAIT,
        RD_PRESENT,
        DONE
    } seq_state_t;

    // Eight-bit counter increment that sticks at 255
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? 8'hFF : v + 8'd1;
    endfunction

endpackage

// File: rtl/histogram_frame_sequencer_streamer.sv
// Readout engine: walks every bin, waits out the histogram read latency and
// holds each count on a valid/ready stream until the consumer takes it.
module hist_readout_streamer
    import histogram_frame_sequencer_pkg::*;
#(
    parameter int NUM_BINS = 1024,
    parameter int BIN_W    = DEF_BIN_W,
    parameter int COUNT_W  = DEF_COUNT_W,
    parameter int READ_LAT = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               active,
    output logic               done,
    output logic [BIN_W-1:0]   rd_bin,
    input  logic [COUNT_W-1:0] hist_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BIN_W-1:0]   out_bin,
    output logic [COUNT_W-1:0] out_data,
    output logic               out_last
);

    localparam logic [BIN_W-1:0] LAST_BIN  = BIN_W'(NUM_BINS - 1);
    localparam logic [2:0]       WAIT_LAST = 3'(READ_LAT - 1);

    seq_state_t         state_q, state_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic [2:0]         wait_q, wait_d;
    logic [COUNT_W-1:0] data_q, data_d;

    // State, bin index, latency counter and captured count registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            bin_q   <= '0;
            wait_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            wait_q  <= wait_d;
            data_q  <= data_d;
        end
    end

    // Address -> wait READ_LAT -> present, advancing one bin per accepted beat
    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        wait_d  = wait_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RD_ADDR;
                    bin_d   = '0;
                end
            end
            RD_ADDR: begin
                state_d = RD_WAIT;
                wait_d  = '0;
            end
            RD_WAIT: begin
                if (wait_q == WAIT_LAST) begin
                    state_d = RD_PRESENT;
                    data_d  = hist_data;
                end else begin
                    wait_d = wait_q + 3'd1;
                end
            end
            RD_PRESENT: begin
                if (out_ready) begin
                    if (bin_q == LAST_BIN) begin
                        state_d = IDLE;
                    end else begin
                        state_d = RD_ADDR;
                        bin_d   = bin_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Stream outputs are zero whenever no beat is being presented
    always_comb begin
        active    = (state_q != IDLE);
        out_valid = (state_q == RD_PRESENT);
        out_bin   = out_valid ? bin_q : '0;
        out_data  = out_valid ? data_q : '0;
        out_last  = out_valid && (bin_q == LAST_BIN);
        done      = out_last && out_ready;
        rd_bin    = active ? bin_q : '0;
    end

endmodule

// File: rtl/histogram_frame_sequencer.sv
// Frame-level controller: clears the bin RAM, gates one frame of pixels into it,
// lets the accumulate pipeline drain, then streams every bin count out.
module histogram_frame_sequencer
    import histogram_frame_sequencer_pkg::*;
#(
    parameter int NUM_BINS  = 1024,
    parameter int BIN_W     = DEF_BIN_W,
    parameter int COUNT_W   = DEF_COUNT_W,
    parameter int READ_LAT  = 2,
    parameter int DRAIN_CYC = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               frame_start,
    input  logic               frame_end,
    input  logic [BIN_W-1:0]   pixel_in,
    input  logic               pixel_valid_in,
    output logic               hist_rw,
    output logic               hist_clr,
    output logic [BIN_W-1:0]   hist_pixel,
    output logic               hist_pixel_valid,
    output logic [BIN_W-1:0]   hist_bin,
    input  logic [COUNT_W-1:0] hist_data,
    output logic               hist_image_done,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BIN_W-1:0]   out_bin,
    output logic [COUNT_W-1:0] out_data,
    output logic               out_last,
    output logic               busy,
    output logic [15:0]        frame_count,
    output logic [7:0]         drop_count
);

    localparam logic [BIN_W-1:0] LAST_BIN   = BIN_W'(NUM_BINS - 1);
    localparam logic [BIN_W-1:0] DRAIN_LAST = BIN_W'(DRAIN_CYC - 1);

    // The main FSM parks in RD_ADDR for the whole readout; the streamer owns the per-bin sub-states
    seq_state_t       state_q, state_d;
    logic [BIN_W-1:0] cnt_q, cnt_d;
    logic [15:0]      frame_count_q, frame_count_d;
    logic [7:0]       drop_count_q, drop_count_d;
    logic [BIN_W-1:0] hist_pixel_q, hist_pixel_d;
    logic             hist_pixel_valid_q, hist_pixel_valid_d;

    logic             accept;
    logic             drain_last;
    logic             rd_active;
    logic             rd_done;
    logic [BIN_W-1:0] rd_bin;

    assign accept     = ((state_q == ARMED) && frame_start) || (state_q == ACCUM);
    assign drain_last = (state_q == DRAIN) && (cnt_q == DRAIN_LAST);

    hist_readout_streamer #(
        .NUM_BINS (NUM_BINS),
        .BIN_W    (BIN_W),
        .COUNT_W  (COUNT_W),
        .READ_LAT (READ_LAT)
    ) u_streamer (
        .clk       (clk),
        .rst       (rst),
        .start     (drain_last),
        .active    (rd_active),
        .done      (rd_done),
        .rd_bin    (rd_bin),
        .hist_data (hist_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bin   (out_bin),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    // Sequencer state, shared clear/drain counter, statistics and the pixel pipeline stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q            <= IDLE;
            cnt_q              <= '0;
            frame_count_q      <= '0;
            drop_count_q       <= '0;
            hist_pixel_q       <= '0;
            hist_pixel_valid_q <= 1'b0;
        end else begin
            state_q            <= state_d;
            cnt_q              <= cnt_d;
            frame_count_q      <= frame_count_d;
            drop_count_q       <= drop_count_d;
            hist_pixel_q       <= hist_pixel_d;
            hist_pixel_valid_q <= hist_pixel_valid_d;
        end
    end

    // Frame sequencing, pixel gating and dropped frame_start accounting
    always_comb begin
        state_d            = state_q;
        cnt_d              = cnt_q;
        frame_count_d      = frame_count_q;
        drop_count_d       = drop_count_q;
        hist_pixel_d       = accept ? pixel_in : '0;
        hist_pixel_valid_d = accept && pixel_valid_in;

        if (frame_start && (state_q inside {CLEAR, ACCUM, DRAIN, RD_ADDR, DONE})) begin
            drop_count_d = sat_inc8(drop_count_q);
        end

        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_BIN) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (frame_start) begin
                    state_d = frame_end ? DRAIN : ACCUM;
                    cnt_d   = '0;
                end else if (!enable) begin
                    state_d = IDLE;
                end
            end
            ACCUM: begin
                if (frame_end) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end
            end
            DRAIN: begin
                cnt_d = cnt_q + 1'b1;
                if (drain_last) begin
                    state_d = RD_ADDR;
                end
            end
            RD_ADDR: begin
                if (rd_done) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                frame_count_d = frame_count_q + 16'd1;
                state_d       = enable ? CLEAR : IDLE;
                cnt_d         = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    // Histogram port controls decoded from the sequencer state
    always_comb begin
        hist_rw          = (state_q inside {ARMED, ACCUM, DRAIN}) ? HIST_WRITE : HIST_READ;
        hist_clr         = (state_q == CLEAR);
        hist_bin         = (state_q == CLEAR) ? cnt_q : (rd_active ? rd_bin : '0);
        hist_image_done  = drain_last;
        hist_pixel       = hist_pixel_q;
        hist_pixel_valid = hist_pixel_valid_q;
        busy             = !(state_q inside {IDLE, ARMED});
        frame_count      = frame_count_q;
        drop_count       = drop_count_q;
    end

endmodule

// File: tb/tb_histogram_frame_sequencer.sv
// Testbench for histogram_frame_sequencer with a behavioural bin RAM, a per-frame
// reference histogram and a scoreboard monitor on the readout stream.
module tb_histogram_frame_sequencer;

    localparam int NUM_BINS  = 8;
    localparam int BIN_W     = 3;
    localparam int COUNT_W   = 24;
    localparam int READ_LAT  = 2;
    localparam int DRAIN_CYC = 4;

    typedef struct packed {
        logic [BIN_W-1:0]   bin;
        logic [COUNT_W-1:0] data;
        logic               last;
    } beat_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               enable;
    logic               frame_start;
    logic               frame_end;
    logic [BIN_W-1:0]   pixel_in;
    logic               pixel_valid_in;
    logic               hist_rw;
    logic               hist_clr;
    logic [BIN_W-1:0]   hist_pixel;
    logic               hist_pixel_valid;
    logic [BIN_W-1:0]   hist_bin;
    logic [COUNT_W-1:0] hist_data;
    logic               hist_image_done;
    logic               out_valid;
    logic               out_ready;
    logic [BIN_W-1:0]   out_bin;
    logic [COUNT_W-1:0] out_data;
    logic               out_last;
    logic               busy;
    logic [15:0]        frame_count;
    logic [7:0]         drop_count;

    int    compared   = 0;
    int    mismatched = 0;
    beat_t expQ[$];
    int    pixQ[$];
    int    vldQ[$];
    int    expFrames = 0;
    int    expDrops  = 0;
    int    imageDoneCycles = 0;
    int    readyMode = 0;
    int    clrCount;

    always #5 clk = ~clk;

    histogram_frame_sequencer #(
        .NUM_BINS  (NUM_BINS),
        .BIN_W     (BIN_W),
        .COUNT_W   (COUNT_W),
        .READ_LAT  (READ_LAT),
        .DRAIN_CYC (DRAIN_CYC)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .enable           (enable),
        .frame_start      (frame_start),
        .frame_end        (frame_end),
        .pixel_in         (pixel_in),
        .pixel_valid_in   (pixel_valid_in),
        .hist_rw          (hist_rw),
        .hist_clr         (hist_clr),
        .hist_pixel       (hist_pixel),
        .hist_pixel_valid (hist_pixel_valid),
        .hist_bin         (hist_bin),
        .hist_data        (hist_data),
        .hist_image_done  (hist_image_done),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_bin          (out_bin),
        .out_data         (out_data),
        .out_last         (out_last),
        .busy             (busy),
        .frame_count      (frame_count),
        .drop_count       (drop_count)
    );

    // Stand-in for the histogram block: clear, accumulate, and a READ_LAT-deep read pipe
    logic [COUNT_W-1:0] ram [NUM_BINS];
    logic [COUNT_W-1:0] rdPipe [READ_LAT];

    always @(posedge clk) begin
        if (hist_clr) begin
            ram[hist_bin] <= '0;
        end else if (hist_rw && hist_pixel_valid) begin
            ram[hist_pixel] <= ram[hist_pixel] + 1'b1;
        end
        rdPipe[0] <= ram[hist_bin];
        for (int k = 1; k < READ_LAT; k++) begin
            rdPipe[k] <= rdPipe[k-1];
        end
    end

    assign hist_data = rdPipe[READ_LAT-1];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Scoreboard monitor: every presented beat must match the head of the expected queue
    always @(negedge clk) begin
        if (!rst) begin
            if (hist_image_done) imageDoneCycles++;
            if (out_valid) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_beat", 32'(out_valid), 32'd0);
                end else begin
                    checkOutput("out_bin", 32'(out_bin), 32'(expQ[0].bin));
                    checkOutput("out_data", 32'(out_data), 32'(expQ[0].data));
                    checkOutput("out_last", 32'(out_last), 32'(expQ[0].last));
                    if (out_ready) void'(expQ.pop_front());
                end
            end
        end
    end

    // Consumer back-pressure: always ready, one cycle in three, or random
    initial begin
        int phase = 0;
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (readyMode)
                0: out_ready = 1'b1;
                1: begin
                    out_ready = (phase == 0);
                    phase = (phase + 1) % 3;
                end
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Background noise on the pixel port outside frames must never reach the histogram
    task automatic idleDrive();
        frame_start    = 1'b0;
        frame_end      = 1'b0;
        pixel_in       = BIN_W'($urandom_range(0, NUM_BINS - 1));
        pixel_valid_in = 1'($urandom_range(0, 1));
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_flags"}, 32'({hist_rw, hist_clr, hist_pixel_valid, hist_image_done,
                                          out_valid, out_last, busy}), 32'd0);
        checkOutput({tag, "_out_bin"}, 32'(out_bin), 32'd0);
        checkOutput({tag, "_out_data"}, 32'(out_data), 32'd0);
        checkOutput({tag, "_hist_bin"}, 32'(hist_bin), 32'd0);
        checkOutput({tag, "_hist_pixel"}, 32'(hist_pixel), 32'd0);
        checkOutput({tag, "_frame_count"}, 32'(frame_count), 32'd0);
        checkOutput({tag, "_drop_count"}, 32'(drop_count), 32'd0);
    endtask

    task automatic fillRandom(input int n);
        pixQ.delete();
        vldQ.delete();
        for (int i = 0; i < n; i++) begin
            pixQ.push_back($urandom_range(0, NUM_BINS - 1));
            vldQ.push_back(($urandom_range(0, 3) != 0) ? 1 : 0);
        end
    endtask

    task automatic waitArmed();
        int n = 0;
        while (!(hist_rw && !busy) && n < 200) begin
            idleDrive();
            tick();
            n++;
        end
        checkOutput("wait_armed", 32'(hist_rw && !busy), 32'd1);
    endtask

    // Drive one frame from pixQ/vldQ and queue the histogram it should produce
    task automatic applyStimulus(input int dropA, input int dropB, input bit dropEnable);
        int    expCnt[NUM_BINS];
        int    n = pixQ.size();
        beat_t b;
        for (int k = 0; k < NUM_BINS; k++) expCnt[k] = 0;
        for (int i = 0; i < n; i++) begin
            frame_start    = (i == 0) || (i == dropA) || (i == dropB);
            frame_end      = (i == n - 1);
            pixel_in       = BIN_W'(pixQ[i]);
            pixel_valid_in = (vldQ[i] != 0);
            if (vldQ[i] != 0) expCnt[pixQ[i]]++;
            if (i != 0 && frame_start) expDrops = (expDrops < 255) ? expDrops + 1 : 255;
            if (dropEnable && i == 1) enable = 1'b0;
            tick();
        end
        idleDrive();
        for (int k = 0; k < NUM_BINS; k++) begin
            b.bin  = BIN_W'(k);
            b.data = COUNT_W'(expCnt[k]);
            b.last = (k == NUM_BINS - 1);
            expQ.push_back(b);
        end
    endtask

    task automatic waitFrameDone(input bit dropInReadout);
        int n = 0;
        bit dropped = 1'b0;
        expFrames++;
        while (frame_count != 16'(expFrames) && n < 2000) begin
            idleDrive();
            if (dropInReadout && !dropped && out_valid) begin
                frame_start = 1'b1;
                dropped = 1'b1;
                expDrops++;
            end
            tick();
            n++;
        end
        idleDrive();
        checkOutput("frame_count", 32'(frame_count), 32'(expFrames));
        checkOutput("drop_count", 32'(drop_count), 32'(expDrops));
        checkOutput("beats_left", 32'(expQ.size()), 32'd0);
        checkOutput("image_done_cycles", 32'(imageDoneCycles), 32'd1);
        imageDoneCycles = 0;
    endtask

    initial begin
        int  n;
        bit  found;
        rst = 1'b1;
        enable = 1'b0;
        frame_start = 1'b0;
        frame_end = 1'b0;
        pixel_in = '0;
        pixel_valid_in = 1'b0;
        #1;
        checkAllZero("reset");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        enable = 1'b1;

        $display("[TB] bin clear sweep");
        clrCount = 0;
        for (int c = 0; c < 12; c++) begin
            idleDrive();
            tick();
            if (hist_clr) begin
                checkOutput("clr_bin", 32'(hist_bin), 32'(clrCount));
                clrCount++;
            end
        end
        checkOutput("clr_cycles", 32'(clrCount), 32'(NUM_BINS));
        checkOutput("armed_rw", 32'(hist_rw), 32'd1);
        checkOutput("armed_busy", 32'(busy), 32'd0);

        $display("[TB] directed frame 3,3,5,7");
        readyMode = 0;
        pixQ = '{3, 3, 5, 7};
        vldQ = '{1, 1, 1, 1};
        applyStimulus(-1, -1, 1'b0);
        waitFrameDone(1'b0);

        $display("[TB] frame with drops and 1-in-3 ready");
        waitArmed();
        readyMode = 1;
        fillRandom(12);
        applyStimulus(3, 7, 1'b0);
        waitFrameDone(1'b1);

        $display("[TB] empty frame");
        waitArmed();
        readyMode = 0;
        pixQ = '{2};
        vldQ = '{1};
        applyStimulus(-1, -1, 1'b0);
        waitFrameDone(1'b0);

        $display("[TB] random frames");
        readyMode = 2;
        for (int f = 0; f < 3; f++) begin
            waitArmed();
            fillRandom($urandom_range(1, 20));
            applyStimulus(-1, -1, 1'b0);
            waitFrameDone(1'b0);
        end

        $display("[TB] reset during readout");
        waitArmed();
        readyMode = 0;
        fillRandom(10);
        applyStimulus(-1, -1, 1'b0);
        n = 0;
        found = 1'b0;
        while (!found && n < 400) begin
            @(negedge clk);
            if (out_valid && out_bin == 3'd4) found = 1'b1;
            n++;
        end
        checkOutput("reach_bin4", 32'(found), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        checkAllZero("abort");
        expQ.delete();
        imageDoneCycles = 0;
        expFrames = 0;
        expDrops = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("restart_clr", 32'(hist_clr), 32'd1);
        checkOutput("restart_bin", 32'(hist_bin), 32'd0);
        checkOutput("restart_frame_count", 32'(frame_count), 32'd0);

        $display("[TB] enable dropped mid-frame");
        waitArmed();
        readyMode = 2;
        fillRandom(8);
        applyStimulus(-1, -1, 1'b1);
        waitFrameDone(1'b0);
        repeat (3) begin
            idleDrive();
            tick();
        end
        checkOutput("idle_rw", 32'(hist_rw), 32'd0);
        checkOutput("idle_busy", 32'(busy), 32'd0);
        checkOutput("idle_clr", 32'(hist_clr), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/histogram_frame_sequencer.md
Name: histogram_frame_sequencer

Overview:
Frame-level controller for the histogram datapath: clears the bin RAM, gates pixels into it for exactly one frame, then walks every bin and streams the counts out on a valid/ready interface.
Owns the histogram's rw, address, pixel_valid and image_done controls; the histogram block itself holds no sequencing logic.
Sits between the sensor pixel pipeline and the host readout path, on the same clock as the histogram port.

Parameters:
NUM_BINS, 1024, number of histogram bins (power of two)
BIN_W, 10, bin address / pixel width, = log2(NUM_BINS)
COUNT_W, 24, bin count width
READ_LAT, 2, cycles from hist_bin change to hist_data valid (1..7)
DRAIN_CYC, 4, cycles after frame_end before readout (covers read-modify-write pipeline)

Ports:
clk  in  1  sole clock
rst  in  1  asynchronous active-high reset
enable  in  1  level; arm for frames while high
frame_start  in  1  one-cycle pulse, first pixel may arrive same cycle
frame_end  in  1  one-cycle pulse, after last pixel
pixel_in  in  BIN_W  pixel value
pixel_valid_in  in  1  pixel qualifier
hist_rw  out  1  1 = accumulate (write), 0 = read
hist_clr  out  1  clear strobe for address on hist_bin
hist_pixel  out  BIN_W  pixel forwarded to histogram
hist_pixel_valid  out  1  gated pixel qualifier
hist_bin  out  BIN_W  read/clear address
hist_data  in  COUNT_W  bin count from histogram
hist_image_done  out  1  one-cycle pulse at end of DRAIN
out_valid  out  1  stream valid
out_ready  in  1  stream ready
out_bin  out  BIN_W  bin index of out_data
out_data  out  COUNT_W  bin count
out_last  out  1  high with bin NUM_BINS-1
busy  out  1  high in any state except IDLE/ARMED
frame_count  out  16  completed frames, wraps
drop_count  out  8  frame_starts ignored, saturates at 255

Behaviour:
- Reset (async assert, sync release): state IDLE, all outputs 0, counters 0, hist_rw 0.
- IDLE: if enable -> CLEAR, bin counter 0.
- CLEAR: hist_rw=0, hist_clr=1, hist_bin = counter; counter +1 per cycle; after bin NUM_BINS-1 (exactly NUM_BINS cycles) -> ARMED.
- ARMED: hist_rw=1. frame_start -> ACCUM. enable low -> IDLE. frame_end alone ignored.
- ACCUM: hist_rw=1; hist_pixel_valid = pixel_valid_in, hist_pixel = pixel_in, both registered (1-cycle latency). frame_start in ACCUM -> drop_count+1, no state change. frame_end -> DRAIN. Pixels present on the frame_start cycle are accepted. Pixels on the frame_end cycle are accepted.
- frame_start and frame_end same cycle in ARMED: empty frame; go directly to DRAIN; that cycle's pixel accepted.
- DRAIN: hist_pixel_valid=0, hist_rw=1 for DRAIN_CYC cycles. On the last cycle, hist_image_done=1 for one cycle. Then -> READOUT with bin 0, hist_rw=0.
- READOUT, per bin, three sub-states:
  - RD_ADDR: drive hist_bin.
  - RD_WAIT: READ_LAT cycles.
  - RD_PRESENT: capture hist_data into out_data, out_bin=bin, out_valid=1, out_last=(bin==NUM_BINS-1).
  - out_data/out_bin/out_last stable while out_valid && !out_ready.
  - Transfer on out_valid&&out_ready. After a non-last transfer, bin+1 -> RD_ADDR. After the last transfer -> DONE.
  - Minimum READ_LAT+2 cycles per bin.
- DONE: frame_count+1 (wraps 65535->0); -> CLEAR if enable, else IDLE.
- frame_start in CLEAR/DRAIN/READOUT/DONE: drop_count+1 (saturating), no other effect.
- pixel_valid_in outside ACCUM (and the frame_start/frame_end cycles above) never reaches hist_pixel_valid.
- enable deasserted mid-frame: current frame completes through DONE, then IDLE.
- rst mid-readout: stream aborts, out_valid drops immediately, no partial out_last.
- hist_clr is high only in CLEAR. hist_rw is 0 in IDLE/CLEAR/READOUT/DONE.

Decomposition:
- Shared package: state enum (IDLE, CLEAR, ARMED, ACCUM, DRAIN, RD_ADDR, RD_WAIT, RD_PRESENT, DONE), BIN_W/COUNT_W defaults, hist_rw encoding constants (READ=0, WRITE=1).
- One natural sub-module: hist_readout_streamer, the RD_ADDR/RD_WAIT/RD_PRESENT address-wait-hold engine with valid/ready. Main FSM hands it start and receives done.

Test Plan:
- NUM_BINS=8: enable=1 after reset -> hist_clr high exactly 8 cycles with hist_bin 0..7, then ARMED with hist_rw=1.
- Frame with pixels 3,3,5,7 (valid), behavioural histogram model -> stream gives 8 beats: bin3=2, bin5=1, bin7=1, others 0; out_last only on bin 7; frame_count=1.
- out_ready toggled 1-of-3 cycles during readout -> no beat lost or duplicated; out_data/out_bin stable while stalled.
- frame_start pulsed during READOUT and twice during ACCUM -> drop_count=3, the in-progress frame's counts unaffected.
- Same-cycle frame_start+frame_end with pixel 2 valid -> DRAIN directly, readout bin2=1, hist_image_done single pulse.
- rst asserted mid-READOUT at bin 4 -> all outputs 0 asynchronously. After release with enable=1 -> CLEAR restarts at bin 0, frame_count=0.
